// File: rtl/mant_post_add_normalizer_if.sv
// Handshake bundle for the post-add mantissa normalizer.
// master drives operands and out_ready; slave is the normalizer.
interface mant_post_add_normalizer_if #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] mant_in;
    logic              carry_in;
    logic [EXP_W-1:0]  exp_in;
    logic              sign_in;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic              sign_out;
    logic              guard_out;
    logic              zero_out;
    logic              underflow_out;
    logic              overflow_out;

    modport master (
        output in_valid, mant_in, carry_in, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, sign_out,
        input  guard_out, zero_out, underflow_out, overflow_out
    );

    modport slave (
        input  in_valid, mant_in, carry_in, exp_in, sign_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, sign_out,
        output guard_out, zero_out, underflow_out, overflow_out
    );
endinterface

// File: rtl/mant_post_add_normalizer.sv
// Normalizes the adder sum so bit MANT_W-1 is the leading one.
// Ports: clk, rst (sync, active-high), bus (slave side of the if).
module mant_post_add_normalizer #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    mant_post_add_normalizer_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [MANT_W:0]  w;
    logic [EXP_W-1:0] e;
    logic             s;
    logic             guard;
    logic             zero;
    logic             uf;
    logic             of;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            w     <= '0;
            e     <= '0;
            s     <= 1'b0;
            guard <= 1'b0;
            zero  <= 1'b0;
            uf    <= 1'b0;
            of    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        w     <= {bus.carry_in, bus.mant_in};
                        e     <= bus.exp_in;
                        s     <= bus.sign_in;
                        guard <= 1'b0;
                        zero  <= 1'b0;
                        uf    <= 1'b0;
                        of    <= 1'b0;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (w == '0) begin
                        zero  <= 1'b1;
                        e     <= '0;
                        state <= DONE;
                    end else if (w[MANT_W]) begin
                        // carry out: drop one bit into guard
                        w     <= {1'b0, w[MANT_W:1]};
                        guard <= w[0];
                        if (&e) begin
                            of <= 1'b1;
                        end else begin
                            e <= e + EXP_W'(1);
                        end
                        state <= DONE;
                    end else if (w[MANT_W-1]) begin
                        state <= DONE;
                    end else if (e == '0) begin
                        // exponent exhausted: leave as denormal
                        uf    <= 1'b1;
                        state <= DONE;
                    end else begin
                        w <= {w[MANT_W-1:0], 1'b0};
                        e <= e - EXP_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == DONE);
    assign bus.mant_out      = w[MANT_W-1:0];
    assign bus.exp_out       = e;
    assign bus.sign_out      = s;
    assign bus.guard_out     = guard;
    assign bus.zero_out      = zero;
    assign bus.underflow_out = uf;
    assign bus.overflow_out  = of;
endmodule

// File: tb/tb_mant_post_add_normalizer.sv
// Scoreboard bench for mant_post_add_normalizer.
// Expected results are queued at drive time, popped at out_valid.
module tb_mant_post_add_normalizer;
    localparam int MW = 23;
    localparam int EW = 8;

    typedef struct packed {
        logic [22:0] mant;
        logic [7:0]  e;
        logic        sign;
        logic        guard;
        logic        zero;
        logic        uf;
        logic        of;
        logic [7:0]  lat;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mant_post_add_normalizer_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

    mant_post_add_normalizer #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   total = 0;
    int   bad   = 0;
    res_t sb[$];

    // Reference: leading-zero count instead of stepwise shifting.
    function automatic res_t model(logic c, logic [22:0] m,
                                   logic [7:0] e, logic s);
        res_t r;
        int   lz;
        r      = '0;
        r.sign = s;
        if (!c && m == 23'h0) begin
            r.zero = 1'b1;
            r.lat  = 8'd1;
        end else if (c) begin
            r.mant  = {1'b1, m[22:1]};
            r.guard = m[0];
            if (e == 8'hFF) begin
                r.e  = e;
                r.of = 1'b1;
            end else begin
                r.e = e + 8'd1;
            end
            r.lat = 8'd1;
        end else begin
            lz = 0;
            while (!m[22-lz]) lz++;
            if (lz <= int'(e)) begin
                r.mant = m << lz;
                r.e    = e - 8'(lz);
                r.lat  = 8'(lz + 1);
            end else begin
                r.mant = m << e;
                r.e    = 8'h00;
                r.uf   = 1'b1;
                r.lat  = e + 8'd1;
            end
        end
        return r;
    endfunction

    function automatic res_t observe(int lat);
        res_t o;
        o.mant  = bus.mant_out;
        o.e     = bus.exp_out;
        o.sign  = bus.sign_out;
        o.guard = bus.guard_out;
        o.zero  = bus.zero_out;
        o.uf    = bus.underflow_out;
        o.of    = bus.overflow_out;
        o.lat   = 8'(lat);
        return o;
    endfunction

    // Called at #1 after a posedge with the block expected idle.
    task automatic send(input logic c, input logic [22:0] m,
                        input logic [7:0] e, input logic s,
                        input res_t x, input bit push);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_in_ready got=%b want=1", bus.in_ready);
        end
        bus.carry_in = c;
        bus.mant_in  = m;
        bus.exp_in   = e;
        bus.sign_in  = s;
        bus.in_valid = 1'b1;
        if (push) sb.push_back(x);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic get_obs(output res_t o, output bit to);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
        to = !bus.out_valid;
        o  = observe(lat);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.carry_in = 1'b1;
        bus.mant_in  = 23'h7FFFFF;
        bus.exp_in   = 8'hFF;
        bus.sign_in  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
        end
        total++;
        if (observe(0) !== res_t'(0)) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", observe(0));
        end
    endtask

    task automatic run_named(input string nm, input logic c,
                             input logic [22:0] m, input logic [7:0] e,
                             input logic s, input res_t x);
        res_t o;
        res_t w;
        bit   to;
        send(c, m, e, s, x, 1'b1);
        get_obs(o, to);
        w = sb.pop_front();
        total++;
        if (to) begin
            bad++;
            $display("FAIL %s timeout waiting for out_valid", nm);
        end else if (o !== w) begin
            bad++;
            $display("FAIL %s got mant=%h exp=%h s=%b g=%b z=%b uf=%b of=%b lat=%0d want mant=%h exp=%h s=%b g=%b z=%b uf=%b of=%b lat=%0d",
                     nm, o.mant, o.e, o.sign, o.guard, o.zero, o.uf,
                     o.of, o.lat, w.mant, w.e, w.sign, w.guard, w.zero,
                     w.uf, w.of, w.lat);
        end
        release_out();
    endtask

    task automatic test_carry();
        run_named("carry", 1'b1, 23'h000001, 8'h80, 1'b1,
                  res_t'{mant:23'h400000, e:8'h81, sign:1'b1, guard:1'b1,
                         zero:1'b0, uf:1'b0, of:1'b0, lat:8'd1});
    endtask

    task automatic test_left_shift();
        run_named("left_shift", 1'b0, 23'h000100, 8'h80, 1'b0,
                  res_t'{mant:23'h400000, e:8'h72, sign:1'b0, guard:1'b0,
                         zero:1'b0, uf:1'b0, of:1'b0, lat:8'd15});
    endtask

    task automatic test_zero();
        run_named("zero", 1'b0, 23'h000000, 8'h55, 1'b1,
                  res_t'{mant:23'h0, e:8'h00, sign:1'b1, guard:1'b0,
                         zero:1'b1, uf:1'b0, of:1'b0, lat:8'd1});
    endtask

    task automatic test_underflow();
        run_named("underflow", 1'b0, 23'h000001, 8'h03, 1'b0,
                  res_t'{mant:23'h000008, e:8'h00, sign:1'b0, guard:1'b0,
                         zero:1'b0, uf:1'b1, of:1'b0, lat:8'd4});
    endtask

    task automatic test_overflow();
        run_named("overflow", 1'b1, 23'h7FFFFF, 8'hFF, 1'b0,
                  res_t'{mant:23'h7FFFFF, e:8'hFF, sign:1'b0, guard:1'b1,
                         zero:1'b0, uf:1'b0, of:1'b1, lat:8'd1});
    endtask

    task automatic test_exact_fit();
        run_named("exact_fit", 1'b0, 23'h000001, 8'd22, 1'b1,
                  res_t'{mant:23'h400000, e:8'h00, sign:1'b1, guard:1'b0,
                         zero:1'b0, uf:1'b0, of:1'b0, lat:8'd23});
    endtask

    task automatic test_hold();
        res_t o;
        res_t w;
        res_t snap;
        bit   to;
        send(1'b0, 23'h000400, 8'h40, 1'b1, model(1'b0, 23'h000400,
             8'h40, 1'b1), 1'b1);
        get_obs(o, to);
        w = sb.pop_front();
        total++;
        if (to || o !== w) begin
            bad++;
            $display("FAIL hold_result got=%h want=%h timeout=%b", o, w, to);
        end
        snap = observe(0);
        repeat (5) begin
            @(posedge clk);
            #1;
            total++;
            if (observe(0) !== snap || bus.out_valid !== 1'b1 ||
                bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable got=%h v=%b r=%b want=%h v=1 r=0",
                         observe(0), bus.out_valid, bus.in_ready, snap);
            end
        end
        release_out();
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release got r=%b v=%b want r=1 v=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        send(1'b0, 23'h000001, 8'h80, 1'b0, res_t'(0), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_busy got in_ready=%b want=0", bus.in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            observe(0) !== res_t'(0)) begin
            bad++;
            $display("FAIL mid_reset got r=%b v=%b out=%h want r=1 v=0 out=0",
                     bus.in_ready, bus.out_valid, observe(0));
        end
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_no_output got=%0d want=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic        c;
            logic [22:0] m;
            logic [7:0]  e;
            logic        s;
            res_t        o;
            res_t        w;
            bit          to;
            c = ($urandom_range(0, 3) == 0);
            m = 23'($urandom) & (23'h7FFFFF >> $urandom_range(0, 22));
            if ($urandom_range(0, 7) == 0) m = 23'h0;
            e = 8'($urandom);
            if (i % 6 == 5) e = 8'hFF;
            if (i % 6 == 4) e = 8'($urandom_range(0, 6));
            s = 1'($urandom);
            send(c, m, e, s, model(c, m, e, s), 1'b1);
            get_obs(o, to);
            w = sb.pop_front();
            total++;
            if (to || o !== w) begin
                bad++;
                $display("FAIL b2b_%0d in c=%b m=%h e=%h got=%h want=%h timeout=%b",
                         i, c, m, e, o, w, to);
            end
            release_out();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.carry_in  = 1'b0;
        bus.mant_in   = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        test_reset();
        test_carry();
        test_left_shift();
        test_zero();
        test_underflow();
        test_overflow();
        test_exact_fit();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
